// File: rtl/imm_gen_pipe.sv
// ============================================================================
// imm_gen_pipe : pipelined RV64I immediate decoder with valid/ready + skid buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module imm_gen_pipe #(
  parameter int INSTRSIZE = 32,
  parameter int IMMSIZE   = 64,
  parameter int CNTW      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTRSIZE-1:0] instruction,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IMMSIZE-1:0]   immediate,
  output logic [2:0]           fmt,
  output logic                 illegal,
  output logic [CNTW-1:0]      illegal_count
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic signed [31:0] imm32;
  logic [IMMSIZE-1:0] dec_imm;
  logic [2:0]         dec_fmt;
  logic               dec_illegal;

  logic               skid_full;
  logic [IMMSIZE-1:0] skid_imm;
  logic [2:0]         skid_fmt;
  logic               skid_illegal;
  logic               accept;

  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_ILL;
    dec_illegal = 1'b1;
    case (instruction[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: begin
        dec_fmt     = FMT_I;
        dec_illegal = 1'b0;
        imm32       = {{20{instruction[31]}}, instruction[31:20]};
      end
      7'b0100011: begin
        dec_fmt     = FMT_S;
        dec_illegal = 1'b0;
        imm32       = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      7'b1100011: begin
        dec_fmt     = FMT_B;
        dec_illegal = 1'b0;
        imm32       = {{19{instruction[31]}}, instruction[31], instruction[7],
                       instruction[30:25], instruction[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt     = FMT_U;
        dec_illegal = 1'b0;
        imm32       = {instruction[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_fmt     = FMT_J;
        dec_illegal = 1'b0;
        imm32       = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                       instruction[20], instruction[30:21], 1'b0};
      end
      7'b0110011, 7'b0111011: begin
        dec_fmt     = FMT_R;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_fmt     = FMT_ILL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Signed cast sign-extends the 32-bit immediate to the full width.
  assign dec_imm  = IMMSIZE'(imm32);
  assign in_ready = ~skid_full & ~rst;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      immediate     <= '0;
      fmt           <= FMT_R;
      illegal       <= 1'b0;
      illegal_count <= '0;
      skid_full     <= 1'b0;
      skid_imm      <= '0;
      skid_fmt      <= FMT_R;
      skid_illegal  <= 1'b0;
    end else begin
      if (accept && dec_illegal && (illegal_count != CNT_MAX))
        illegal_count <= illegal_count + CNTW'(1);

      if (!out_valid || out_ready) begin
        // Skid content is always older than anything arriving now.
        if (skid_full) begin
          immediate <= skid_imm;
          fmt       <= skid_fmt;
          illegal   <= skid_illegal;
          out_valid <= 1'b1;
          skid_full <= 1'b0;
        end else if (accept) begin
          immediate <= dec_imm;
          fmt       <= dec_fmt;
          illegal   <= dec_illegal;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_imm     <= dec_imm;
        skid_fmt     <= dec_fmt;
        skid_illegal <= dec_illegal;
        skid_full    <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
// ============================================================================
// tb_imm_gen_pipe : directed + randomized scoreboard bench for imm_gen_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_imm_gen_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, out_ready;
  logic [31:0] instruction;

  logic        in_ready, out_valid, illegal;
  logic [63:0] immediate;
  logic [2:0]  fmt;
  logic [15:0] illegal_count;

  logic        in_ready2, out_valid2, illegal2;
  logic [63:0] immediate2;
  logic [2:0]  fmt2;
  logic [1:0]  illegal_count2;

  imm_gen_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .immediate(immediate), .fmt(fmt), .illegal(illegal), .illegal_count(illegal_count)
  );

  imm_gen_pipe #(.CNTW(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .instruction(instruction), .out_valid(out_valid2), .out_ready(out_ready),
    .immediate(immediate2), .fmt(fmt2), .illegal(illegal2), .illegal_count(illegal_count2)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int passed = 0;
  int total  = 0;
  int cnt    = 0;
  int cnt2   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [63:0] sext(input logic [31:0] v, input int bits);
    longint x;
    x = longint'($signed(v << (32 - bits)));
    x = x >>> (32 - bits);
    return x;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t e;
    e.imm = '0;
    e.ill = 1'b0;
    e.fmt = 3'd0;
    case (ins[6:0])
      7'h13, 7'h03, 7'h67, 7'h1B: begin e.fmt = 3'd1; e.imm = sext(ins[31:20], 12); end
      7'h23: begin e.fmt = 3'd2; e.imm = sext({ins[31:25], ins[11:7]}, 12); end
      7'h63: begin e.fmt = 3'd3; e.imm = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13); end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = sext({ins[31:12], 12'b0}, 32); end
      7'h6F: begin e.fmt = 3'd5; e.imm = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21); end
      7'h33, 7'h3B: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic ordy);
    exp_t e;
    int   sz;
    in_valid    = v;
    instruction = ins;
    out_ready   = ordy;
    #1;
    sz = q.size();
    chk("in_ready", in_ready, sz < 2);
    chk("in_ready_c2", in_ready2, sz < 2);
    chk("out_valid", out_valid, sz > 0);
    chk("out_valid_c2", out_valid2, sz > 0);
    chk("illegal_count", illegal_count, cnt);
    chk("illegal_count_c2", illegal_count2, cnt2);
    if (sz > 0) begin
      chk("immediate", immediate, q[0].imm);
      chk("fmt", fmt, q[0].fmt);
      chk("illegal", illegal, q[0].ill);
      chk("immediate_c2", immediate2, q[0].imm);
      chk("fmt_c2", fmt2, q[0].fmt);
      chk("illegal_c2", illegal2, q[0].ill);
      if (ordy) void'(q.pop_front());
    end
    if (v && sz < 2) begin
      e = ref_decode(ins);
      q.push_back(e);
      if (e.ill) begin
        if (cnt < 65535) cnt++;
        if (cnt2 < 3) cnt2++;
      end
    end
    @(negedge clk);
  endtask

  task automatic peek(input string tag, input logic [63:0] imm, input logic [2:0] f);
    #1;
    chk({tag, "_imm"}, immediate, imm);
    chk({tag, "_fmt"}, fmt, f);
    chk({tag, "_valid"}, out_valid, 1'b1);
  endtask

  task automatic reset_mid();
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_immediate", immediate, 64'd0);
    chk("rst_fmt", fmt, 3'd0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_count", illegal_count, 16'd0);
    chk("rst_count_c2", illegal_count2, 2'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    q.delete();
    cnt  = 0;
    cnt2 = 0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [6:0] ops [12] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                           7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Single transfers: I, S, B, U
    cycle(1'b1, 32'hFFF00093, 1'b1);
    peek("addi", 64'hFFFFFFFFFFFFFFFF, 3'd1);
    cycle(1'b1, 32'h00A12423, 1'b1);
    peek("sw", 64'h0000000000000008, 3'd2);
    cycle(1'b1, 32'hFE000EE3, 1'b1);
    peek("beq", 64'hFFFFFFFFFFFFFFFC, 3'd3);
    cycle(1'b1, 32'h800002B7, 1'b1);
    peek("lui", 64'hFFFFFFFF80000000, 3'd4);
    cycle(1'b0, 32'h0, 1'b1);

    // Backpressure: third instruction held until skid drains
    cycle(1'b1, 32'hFFF00093, 1'b0);
    cycle(1'b1, 32'h00A12423, 1'b0);
    cycle(1'b1, 32'hFE000EE3, 1'b0);
    #1 chk("bp_in_ready_low", in_ready, 1'b0);
    cycle(1'b1, 32'hFE000EE3, 1'b1);
    cycle(1'b1, 32'hFE000EE3, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);

    // Illegal opcode counting and saturation on the 2-bit instance
    cycle(1'b1, 32'h0000007F, 1'b1);
    cycle(1'b1, 32'h0000007F, 1'b1);
    #1 chk("illegal_two", illegal_count, 16'd2);
    chk("illegal_fmt", fmt, 3'd7);
    cycle(1'b1, 32'h0000007F, 1'b1);
    cycle(1'b1, 32'h0000007F, 1'b1);
    cycle(1'b1, 32'h0000007F, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    #1 chk("sat_c2", illegal_count2, 2'd3);
    chk("count_five", illegal_count, 16'd5);

    // Reset with the skid buffer full
    cycle(1'b1, 32'h00100093, 1'b0);
    cycle(1'b1, 32'h00200093, 1'b0);
    reset_mid();
    cycle(1'b1, 32'h00500093, 1'b1);
    peek("post_rst", 64'd5, 3'd1);
    cycle(1'b0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 5) != 0)
        ins[6:0] = ops[$urandom_range(0, 11)];
      cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, pipelined successor to the combinational immediate generator. Decodes the full RV64I immediate set (I, S, B, U, J formats, plus R-type with zero immediate) from a 32-bit instruction. Output is registered behind a valid/ready handshake with a 2-entry skid buffer, so it can sit between fetch and decode without a combinational ready path. Reports the decoded format, flags unknown opcodes, and keeps a saturating count of illegal opcodes.

Parameters:
INSTRSIZE, 32, instruction width; only 32 is supported.
IMMSIZE, 64, immediate width; must be >= 32; sign-extended to this width.
CNTW, 16, width of the illegal-opcode counter.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction valid
in_ready  output  1  block can accept an instruction
instruction  input  INSTRSIZE  instruction word
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
immediate  output  IMMSIZE  signed immediate
fmt  output  3  format: 0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
illegal  output  1  opcode not recognised
illegal_count  output  CNTW  saturating count of accepted illegal opcodes

Behaviour:
- Opcode decode on instruction[6:0]:
  - I-format: 0010011, 0000011, 1100111, 0011011.
  - S-format: 0100011.
  - B-format: 1100011.
  - U-format: 0110111, 0010111.
  - J-format: 1101111.
  - R-format: 0110011, 0111011; immediate 0.
  - Any other opcode: fmt=7, illegal=1, immediate 0.
- Immediate assembly; "sx" means replicate instruction[31] up to IMMSIZE bits:
  - I: sx, [31:20].
  - S: sx, [31:25], [11:7].
  - B: sx, [31], [7], [30:25], [11:8], 1'b0.
  - U: sx, [31:12], 12'b0.
  - J: sx, [31], [19:12], [20], [30:21], 1'b0.
- Handshake:
  - A transfer occurs on any edge where valid and ready are both high.
  - in_valid is ignored while in_ready=0.
  - Latency: an instruction accepted at edge N appears on the outputs after edge N, i.e. in cycle N+1.
  - Throughput: 1 per cycle while out_ready=1.
  - Order is strictly preserved; no drops and no duplicates.
- Output register plus skid register:
  - Accept when out_valid=0, or when out_ready=1 → load the output register directly.
  - Accept when out_valid=1 and out_ready=0 → load the skid register; in_ready falls next cycle.
  - When the output is consumed and the skid is full → the skid moves to the output; in_ready rises next cycle.
  - in_ready = ~skid_full and is driven low while rst=1.
- Outputs are stable while out_valid=1 and out_ready=0.
- illegal_count:
  - Increments by 1 when an illegal instruction is accepted at the input, not when it is output.
  - Saturates at 2^CNTW-1; no wrap.
- Reset (asynchronous, any time including mid-transfer):
  - out_valid=0, immediate=0, fmt=0, illegal=0, illegal_count=0.
  - Skid buffer empties; in-flight data is discarded.
  - in_ready=1 in the first cycle after rst deasserts.

Test Plan:
1. in_valid=1, instruction=0xFFF00093 (addi x1,x0,-1), out_ready=1 → next cycle: out_valid=1, immediate=0xFFFFFFFFFFFFFFFF, fmt=1, illegal=0.
2. instruction=0x00A12423 (sw x10,8(x2)) → immediate=0x0000000000000008, fmt=2.
3. instruction=0xFE000EE3 (beq x0,x0,-4) → immediate=0xFFFFFFFFFFFFFFFC, fmt=3. Then 0x800002B7 (lui x5,0x80000) → immediate=0xFFFFFFFF80000000, fmt=4.
4. Backpressure, with out_ready=0 for 3 cycles:
   - Stream 0xFFF00093, 0x00A12423, 0xFE000EE3 back to back.
   - First two are accepted, then in_ready=0 and the third is held.
   - Release out_ready → results appear in order (-1, 8, -4), then the third is accepted; nothing is lost.
5. instruction=0x0000007F, accepted twice → illegal=1, fmt=7, immediate=0, illegal_count=2. With CNTW forced to 2, five illegals → count saturates at 3.
6. Assert rst while the skid buffer is full → outputs clear immediately (out_valid=0, illegal_count=0). After release, in_ready=1; a new addi 0x00500093 yields immediate=5 one cycle later.
